adder_tester: RTL and testbench

Built-in self-test driver and checker for the registered ripple-carry adder macro. It drives operand pairs into the macro: first a fixed corner-case set, then LFSR pseudo-random pairs. It captures the macro's registered sum and combinational carry, compares both against an internal golden addition, and reports pass/fail, an error count and the index of the first failing vector. It sits beside the adder macro in the macro-test wrapper and shares the adder's clock.

---
 rtl/adder_tester_pkg.sv | 25 ++
 rtl/adder_tester_if.sv | 23 ++
 rtl/adder_tester_lfsr_gen.sv | 40 ++++
 rtl/adder_tester.sv | 155 +++++++++++++++
 tb/tb_adder_tester.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/adder_tester_pkg.sv
// Shared types and constants for the adder built-in self-test driver/checker.
package adder_tester_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned NumCorners = 4;

  // Right-shifting Galois tap masks (maximal length) for the operand-pair LFSR widths.
  function automatic logic [63:0] lfsr_taps(input int unsigned n);
    logic [63:0] taps;
    case (n)
      16:      taps = 64'h0000_0000_0000_B400;
      32:      taps = 64'h0000_0000_8020_0003;
      64:      taps = 64'hD800_0000_0000_0000;
      default: taps = 64'h0;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/adder_tester_if.sv
// Operand/result bus between the self-test block and the registered adder macro.
interface adder_tester_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] a_o;
  logic [WIDTH-1:0] b_o;
  logic [WIDTH-1:0] dut_sum_i;
  logic             dut_carry_i;

  modport master (
    output a_o,
    output b_o,
    input  dut_sum_i,
    input  dut_carry_i
  );

  modport slave (
    input  a_o,
    input  b_o,
    output dut_sum_i,
    output dut_carry_i
  );
endinterface

// File: rtl/adder_tester_lfsr_gen.sv
// N-bit right-shifting Galois LFSR with synchronous load and step; a zero seed loads 1.
module lfsr_gen
  import adder_tester_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [N-1:0] seed_i,
  input  logic         step_i,
  output logic [N-1:0] state_o
);

  localparam logic [63:0] TapsFull = lfsr_taps(N);
  localparam logic [N-1:0] Taps    = TapsFull[N-1:0];
  localparam logic [N-1:0] One     = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == '0) ? One : seed_i;
    end else if (step_i) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? Taps : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= One;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/adder_tester.sv
// Self-test driver/checker for the registered ripple-carry adder: corner vectors, then LFSR
// pairs, each checked one cycle after issue against a golden WIDTH+1-bit addition.
module adder_tester
  import adder_tester_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     num_vectors_i,
  input  logic [2*WIDTH-1:0]   seed_i,
  adder_tester_if.master       adder,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [CNT_W-1:0]     err_count_o,
  output logic [CNT_W-1:0]     first_err_idx_o
);

  localparam logic [CNT_W-1:0] CornerCnt = CNT_W'(NumCorners);
  localparam logic [WIDTH-1:0] AltA      = {(WIDTH/2){2'b10}};
  localparam logic [WIDTH-1:0] AltB      = {(WIDTH/2){2'b01}};
  localparam logic [WIDTH-1:0] OneW      = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH:0]     exp_q, exp_d;
  logic               cap_carry_q, cap_carry_d;
  logic [CNT_W-1:0]   chk_idx_q, chk_idx_d;
  logic               chk_valid_q, chk_valid_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   first_q, first_d;

  logic               lfsr_load, lfsr_step;
  logic [2*WIDTH-1:0] lfsr_state;
  logic [CNT_W-1:0]   next_idx;
  logic               mismatch;

  lfsr_gen #(
    .N (2 * WIDTH)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (lfsr_load),
    .seed_i  (seed_i),
    .step_i  (lfsr_step),
    .state_o (lfsr_state)
  );

  assign next_idx = idx_q + 1'b1;
  // Carry was captured alongside issue; the registered sum arrives a cycle later.
  assign mismatch = chk_valid_q && ({cap_carry_q, adder.dut_sum_i} != exp_q);

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    exp_d       = exp_q;
    cap_carry_d = cap_carry_q;
    chk_idx_d   = chk_idx_q;
    chk_valid_d = 1'b0;
    err_d       = err_q;
    first_d     = first_q;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;

    if (mismatch) begin
      if (err_q != '1) err_d = err_q + 1'b1;
      if (err_q == '0) first_d = chk_idx_q;
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d   = StRun;
          num_d     = (num_vectors_i == '0) ? CornerCnt : num_vectors_i;
          idx_d     = '0;
          a_d       = '0;
          b_d       = '0;
          err_d     = '0;
          first_d   = '0;
          lfsr_load = 1'b1;
        end
      end
      StRun: begin
        exp_d       = {1'b0, a_q} + {1'b0, b_q};
        cap_carry_d = adder.dut_carry_i;
        chk_idx_d   = idx_q;
        chk_valid_d = 1'b1;
        if (idx_q == num_q - 1'b1) begin
          state_d = StDrain;
        end else begin
          idx_d = next_idx;
          if (next_idx < CornerCnt) begin
            unique case (next_idx[1:0])
              2'd0: begin a_d = '0;   b_d = '0;   end
              2'd1: begin a_d = '1;   b_d = OneW; end
              2'd2: begin a_d = '1;   b_d = '1;   end
              2'd3: begin a_d = AltA; b_d = AltB; end
            endcase
          end else begin
            a_d       = lfsr_state[WIDTH-1:0];
            b_d       = lfsr_state[2*WIDTH-1:WIDTH];
            lfsr_step = 1'b1;
          end
        end
      end
      StDrain: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      num_q       <= '0;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      exp_q       <= '0;
      cap_carry_q <= 1'b0;
      chk_idx_q   <= '0;
      chk_valid_q <= 1'b0;
      err_q       <= '0;
      first_q     <= '0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      exp_q       <= exp_d;
      cap_carry_q <= cap_carry_d;
      chk_idx_q   <= chk_idx_d;
      chk_valid_q <= chk_valid_d;
      err_q       <= err_d;
      first_q     <= first_d;
    end
  end

  assign adder.a_o       = a_q;
  assign adder.b_o       = b_q;
  assign busy_o          = (state_q == StRun) || (state_q == StDrain);
  assign done_o          = (state_q == StDone);
  assign pass_o          = done_o && (err_q == '0);
  assign err_count_o     = err_q;
  assign first_err_idx_o = first_q;

endmodule

// File: tb/tb_adder_tester.sv
// Directed bench for adder_tester: a behavioural registered adder with injectable faults.
module tb_adder_tester;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vectors = '0;
  logic [31:0]      seed = '0;
  logic             busy, done, pass;
  logic [CNT_W-1:0] err_count, first_idx;

  logic             fault_bit3 = 1'b0;
  logic             fault_carry0 = 1'b0;

  int checks = 0;
  int errors = 0;
  int cycles;
  logic [15:0] va [0:63];
  logic [15:0] vb [0:63];

  adder_tester_if #(.WIDTH(WIDTH)) bus ();

  adder_tester #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start),
    .num_vectors_i   (num_vectors),
    .seed_i          (seed),
    .adder           (bus.master),
    .busy_o          (busy),
    .done_o          (done),
    .pass_o          (pass),
    .err_count_o     (err_count),
    .first_err_idx_o (first_idx)
  );

  always #5 clk = ~clk;

  // Adder under test: registered sum, combinational carry.
  logic [16:0] full_sum;
  assign full_sum        = {1'b0, bus.a_o} + {1'b0, bus.b_o};
  assign bus.dut_carry_i = fault_carry0 ? 1'b0 : full_sum[16];
  always @(posedge clk) bus.dut_sum_i <= full_sum[15:0] & (fault_bit3 ? 16'hFFF7 : 16'hFFFF);

  // Pulse start then run until done_o; cycles counts edges including the one sampling start.
  task automatic run(input logic [CNT_W-1:0] n, input logic [31:0] s);
    num_vectors = n;
    seed = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1;
    va[0] = bus.a_o;
    vb[0] = bus.b_o;
    while (!done && cycles < 300) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles - 1 < 64) begin
        va[cycles-1] = bus.a_o;
        vb[cycles-1] = bus.b_o;
      end
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL run_timeout: done %b want 1", done); end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, pass, err_count, first_idx, bus.a_o, bus.b_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy %b done %b pass %b err %h first %h a %h b %h want all 0",
               busy, done, pass, err_count, first_idx, bus.a_o, bus.b_o);
    end
  endtask

  task automatic test_good_run();
    run(16'd100, 32'h1234_5678);
    checks++;
    if (cycles != 102) begin errors++; $display("FAIL good_latency: %0d want 102", cycles); end
    checks++;
    if ({pass, err_count, first_idx, busy} !== {1'b1, 16'h0, 16'h0, 1'b0}) begin
      errors++;
      $display("FAIL good_result: pass %b err %h first %h busy %b want 1 0 0 0",
               pass, err_count, first_idx, busy);
    end
    checks++;
    if ({va[0], vb[0], va[1], vb[1], va[2], vb[2], va[3], vb[3]} !==
        {16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 16'hFFFF, 16'hFFFF, 16'hAAAA, 16'h5555}) begin
      errors++;
      $display("FAIL corners: %h %h %h %h %h %h %h %h", va[0], vb[0], va[1], vb[1],
               va[2], vb[2], va[3], vb[3]);
    end
    checks++;
    if ({va[4], vb[4]} !== {16'h5678, 16'h1234}) begin
      errors++;
      $display("FAIL seed_vector: a %h b %h want 5678 1234", va[4], vb[4]);
    end
  endtask

  task automatic test_carry_fault();
    fault_carry0 = 1'b1;
    run(16'd4, 32'h1);
    fault_carry0 = 1'b0;
    checks++;
    if (cycles != 6) begin errors++; $display("FAIL carry_latency: %0d want 6", cycles); end
    checks++;
    if ({err_count, first_idx, pass} !== {16'd2, 16'd1, 1'b0}) begin
      errors++;
      $display("FAIL carry_fault: err %0d first %0d pass %b want 2 1 0",
               err_count, first_idx, pass);
    end
    checks++;
    if ({bus.a_o, bus.b_o} !== {16'hAAAA, 16'h5555}) begin
      errors++;
      $display("FAIL hold_last: a %h b %h want aaaa 5555", bus.a_o, bus.b_o);
    end
  endtask

  // 0xFFFF+0xFFFF = 0x1FFFE has sum bit 3 set, so vector 2 is the first exposure.
  task automatic test_sum_bit3();
    fault_bit3 = 1'b1;
    run(16'd20, 32'h1234_5678);
    fault_bit3 = 1'b0;
    checks++;
    if (err_count == '0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL bit3_detect: err %0d pass %b want nonzero 0", err_count, pass);
    end
    checks++;
    if (first_idx !== 16'd2) begin
      errors++;
      $display("FAIL bit3_first: %0d want 2", first_idx);
    end
  endtask

  task automatic test_short_runs();
    run(16'd0, 32'h1);
    checks++;
    if ({cycles == 6, pass, err_count} !== {1'b1, 1'b1, 16'h0}) begin
      errors++;
      $display("FAIL zero_count: cycles %0d pass %b err %0d want 6 1 0", cycles, pass, err_count);
    end
    run(16'd2, 32'h1);
    checks++;
    if ({cycles == 4, pass, bus.a_o, bus.b_o} !== {1'b1, 1'b1, 16'hFFFF, 16'h0001}) begin
      errors++;
      $display("FAIL two_vectors: cycles %0d pass %b a %h b %h want 4 1 ffff 0001",
               cycles, pass, bus.a_o, bus.b_o);
    end
  endtask

  task automatic test_mid_reset();
    num_vectors = 16'd50;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    test_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    run(16'd5, 32'hCAFE_F00D);
    checks++;
    if ({cycles == 7, pass} !== 2'b11) begin
      errors++;
      $display("FAIL after_reset: cycles %0d pass %b want 7 1", cycles, pass);
    end
  endtask

  task automatic test_zero_seed();
    logic [15:0] ea [0:5];
    logic [15:0] eb [0:5];
    ea = '{16'h0001, 16'h0003, 16'h0002, 16'h0001, 16'h0003, 16'h0002};
    eb = '{16'h0000, 16'h8020, 16'hC030, 16'h6018, 16'hB02C, 16'hD836};
    for (int r = 0; r < 2; r++) begin
      run(16'd10, 32'h0);
      for (int k = 0; k < 6; k++) begin
        checks++;
        if ({va[k+4], vb[k+4]} !== {ea[k], eb[k]}) begin
          errors++;
          $display("FAIL lfsr_run%0d_vec%0d: a %h b %h want %h %h",
                   r, k + 4, va[k+4], vb[k+4], ea[k], eb[k]);
        end
      end
    end
  endtask

  task automatic test_start_in_run();
    num_vectors = 16'd10;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1;
    repeat (3) begin @(posedge clk); #1; cycles++; end
    num_vectors = 16'd3;
    start = 1'b1;
    @(posedge clk); #1;
    cycles++;
    start = 1'b0;
    while (!done && cycles < 300) begin @(posedge clk); #1; cycles++; end
    checks++;
    if ({cycles == 12, pass} !== 2'b11) begin
      errors++;
      $display("FAIL start_ignored: cycles %0d pass %b want 12 1", cycles, pass);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_good_run();
    test_carry_fault();
    test_sum_bit3();
    test_short_runs();
    test_mid_reset();
    test_zero_seed();
    test_start_in_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
